neuron_mac_sequencer: RTL and testbench

Sequences one shared unsigned 8x8 multiplier through an N-element dot product for a single neuron. Each cycle it fetches one input/weight pair from external registered memories, routes the operands to the multiplier, and accumulates the 16-bit products on top of a bias. It returns the sum over a valid/ready handshake. It sits between the layer controller (start/result) and the multiplier plus the input/weight memories.

---
 rtl/neuron_mac_sequencer_pkg.sv | 15 +
 rtl/neuron_mac_sequencer_acc.sv | 42 ++++
 rtl/neuron_mac_sequencer.sv | 90 +++++++++
 tb/tb_neuron_mac_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_sequencer_pkg.sv
// Shared definitions for the neuron MAC datapath: sequencer state encoding
// and the operand/product widths of the shared multiplier.
package neuron_mac_sequencer_pkg;

  localparam int OPND_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

endpackage

// File: rtl/neuron_mac_sequencer_acc.sv
// Unsigned ACC_W accumulator: loads a zero-extended bias, adds zero-extended
// products when enabled, and keeps a sticky flag for any carry out of ACC_W.
module neuron_mac_acc
  import neuron_mac_sequencer_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PROD_W-1:0]   bias,
  input  logic                acc_en,
  input  logic [PROD_W-1:0]   prod,
  output logic [ACC_W-1:0]    acc_p1,
  output logic                ovf
);

  // Sum is one bit wider than the accumulator; the MSB is the carry out.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    return (ACC_W+1)'(a) + (ACC_W+1)'(p);
  endfunction

  logic [ACC_W:0] sum_p0;

  assign sum_p0 = acc_add(acc_p1, prod);

  // Stage p1: accumulator register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p1 <= '0;
      ovf    <= 1'b0;
    end else if (load) begin
      acc_p1 <= ACC_W'(bias);
      ovf    <= 1'b0;
    end else if (acc_en) begin
      acc_p1 <= sum_p0[ACC_W-1:0];
      if (sum_p0[ACC_W]) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Time-multiplexes one 8x8 multiplier over an N_INPUTS dot product plus bias,
// fetching operands from registered memories and returning the sum by valid/ready.
module neuron_mac_sequencer
  import neuron_mac_sequencer_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int ADDR_W   = 3,
  parameter int ACC_W    = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PROD_W-1:0]   bias,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [OPND_W-1:0]   in_data,
  input  logic [OPND_W-1:0]   w_data,
  output logic [OPND_W-1:0]   mul_a,
  output logic [OPND_W-1:0]   mul_b,
  input  logic [PROD_W-1:0]   mul_p,
  output logic [ACC_W-1:0]    result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                ovf
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  mac_state_e state;
  logic       vld_p0;
  logic       acc_load;

  assign mul_a    = in_data;
  assign mul_b    = w_data;
  assign acc_load = (state == ST_IDLE) && start;

  // Stage p0: address issue; read data for the address issued last cycle
  // is on in_data/w_data while vld_p0 is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mem_addr     <= '0;
      vld_p0       <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      vld_p0 <= (state == ST_RUN);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            mem_addr <= '0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (mem_addr == LAST_ADDR) state <= ST_DRAIN;
          else                       mem_addr <= mem_addr + 1'b1;
        end
        ST_DRAIN: begin
          state        <= ST_DONE;
          result_valid <= 1'b1;
        end
        ST_DONE: begin
          if (result_ready) begin
            state        <= ST_IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: accumulate the product of the operands fetched in stage p0
  neuron_mac_acc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (acc_load),
    .bias   (bias),
    .acc_en (vld_p0),
    .prod   (mul_p),
    .acc_p1 (result),
    .ovf    (ovf)
  );

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Scoreboard bench for neuron_mac_sequencer: three instances cover the basic,
// full-width and 16-bit-overflow configurations against shared memory models.
module tb_neuron_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic [15:0] bias = '0;
  logic        result_ready = 1'b0;

  logic [7:0]  x_mem [8];
  logic [7:0]  w_mem [8];

  // instance 0: N=4, ACC_W=24
  logic        busy0, rv0, ovf0;
  logic [2:0]  addr0;
  logic [7:0]  in0, wd0, ma0, mb0;
  logic [15:0] mp0;
  logic [23:0] res0;
  // instance 1: N=8, ACC_W=24
  logic        busy1, rv1, ovf1;
  logic [2:0]  addr1;
  logic [7:0]  in1, wd1, ma1, mb1;
  logic [15:0] mp1;
  logic [23:0] res1;
  // instance 2: N=2, ACC_W=16
  logic        busy2, rv2, ovf2;
  logic [0:0]  addr2;
  logic [7:0]  in2, wd2, ma2, mb2;
  logic [15:0] mp2;
  logic [15:0] res2;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    in0 <= x_mem[addr0]; wd0 <= w_mem[addr0];
    in1 <= x_mem[addr1]; wd1 <= w_mem[addr1];
    in2 <= x_mem[addr2]; wd2 <= w_mem[addr2];
  end

  assign mp0 = 16'(ma0) * 16'(mb0);
  assign mp1 = 16'(ma1) * 16'(mb1);
  assign mp2 = 16'(ma2) * 16'(mb2);

  neuron_mac_sequencer #(.N_INPUTS(4), .ADDR_W(3), .ACC_W(24)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bias(bias), .busy(busy0),
    .mem_addr(addr0), .in_data(in0), .w_data(wd0), .mul_a(ma0), .mul_b(mb0),
    .mul_p(mp0), .result(res0), .result_valid(rv0), .result_ready(result_ready),
    .ovf(ovf0));

  neuron_mac_sequencer #(.N_INPUTS(8), .ADDR_W(3), .ACC_W(24)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bias(bias), .busy(busy1),
    .mem_addr(addr1), .in_data(in1), .w_data(wd1), .mul_a(ma1), .mul_b(mb1),
    .mul_p(mp1), .result(res1), .result_valid(rv1), .result_ready(result_ready),
    .ovf(ovf1));

  neuron_mac_sequencer #(.N_INPUTS(2), .ADDR_W(1), .ACC_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bias(bias), .busy(busy2),
    .mem_addr(addr2), .in_data(in2), .w_data(wd2), .mul_a(ma2), .mul_b(mb2),
    .mul_p(mp2), .result(res2), .result_valid(rv2), .result_ready(result_ready),
    .ovf(ovf2));

  int          sel = 0;
  logic        valid_o, busy_o, ovf_o;
  logic [31:0] result_o, addr_o;

  assign valid_o  = (sel == 0) ? rv0   : (sel == 1) ? rv1   : rv2;
  assign busy_o   = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign ovf_o    = (sel == 0) ? ovf0  : (sel == 1) ? ovf1  : ovf2;
  assign result_o = (sel == 0) ? 32'(res0)  : (sel == 1) ? 32'(res1)  : 32'(res2);
  assign addr_o   = (sel == 0) ? 32'(addr0) : (sel == 1) ? 32'(addr1) : 32'(addr2);

  typedef struct {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    sb_q.push_back(e);
  endtask

  // Called at a negedge with the selected instance idle. hold>0 keeps ready low
  // for that many DONE cycles and pulses start in the middle of them.
  task automatic run_op(input logic [15:0] b, input int n, input int hold,
                        input bit next_start);
    int   lat;
    exp_t e;
    result_ready = (hold == 0);
    bias = b;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    chk("busy_after_start", busy_o, 1);
    chk("ovf_cleared", ovf_o, 0);
    lat = 0;
    while (!valid_o && lat < 40) begin
      if (lat <= n) chk("mem_addr", addr_o, (lat < n) ? lat : n - 1);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, n + 1);
    chk("sb_size", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("result", result_o, e.res);
      chk("ovf", ovf_o, e.ovf);
    end else begin
      e.res = '0;
      e.ovf = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      if (i == 2) start_v[sel] = 1'b1;
      @(negedge clk);
      start_v[sel] = 1'b0;
      chk("hold_valid", valid_o, 1);
      chk("hold_result", result_o, e.res);
      chk("hold_ovf", ovf_o, e.ovf);
      chk("hold_busy", busy_o, 1);
    end
    result_ready = 1'b1;
    if (next_start) start_v[sel] = 1'b1;
    @(negedge clk);
    chk("hs_valid", valid_o, 0);
    chk("hs_idle", busy_o, 0);
    chk("result_kept", result_o, e.res);
    if (!next_start) begin
      @(negedge clk);
      chk("start_not_queued", busy_o, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      x_mem[i] = 8'(i + 1);
      w_mem[i] = 8'(i + 5);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sel = 0;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_addr", addr_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic: 10 + 5 + 12 + 21 + 32
    sel = 0;
    push_exp(32'd80, 1'b0);
    run_op(16'd10, 4, 0, 1'b0);

    // back-to-back with start held through the handshake cycle
    push_exp(32'd70, 1'b0);
    run_op(16'd0, 4, 0, 1'b1);
    push_exp(32'd170, 1'b0);
    run_op(16'd100, 4, 0, 1'b0);

    // backpressure
    push_exp(32'd80, 1'b0);
    run_op(16'd10, 4, 6, 1'b0);

    // max operands on N=8
    for (int i = 0; i < 8; i++) begin
      x_mem[i] = 8'd255;
      w_mem[i] = 8'd255;
    end
    sel = 1;
    push_exp(32'd585735, 1'b0);
    run_op(16'hFFFF, 8, 0, 1'b0);

    // overflow on ACC_W=16, then ovf cleared by the next start
    sel = 2;
    push_exp(32'd64514, 1'b1);
    run_op(16'd0, 2, 0, 1'b0);
    x_mem[0] = 8'd1; w_mem[0] = 8'd1;
    x_mem[1] = 8'd1; w_mem[1] = 8'd1;
    push_exp(32'd2, 1'b0);
    run_op(16'd0, 2, 0, 1'b0);

    // reset during the third RUN cycle
    for (int i = 0; i < 8; i++) begin
      x_mem[i] = 8'(i + 1);
      w_mem[i] = 8'(i + 5);
    end
    sel = 0;
    bias = 16'd10;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_addr", addr_o, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_result", result_o, 0);
    chk("midrst_ovf", ovf_o, 0);
    chk("midrst_addr", addr_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", valid_o, 0);
    push_exp(32'd80, 1'b0);
    run_op(16'd10, 4, 0, 1'b0);

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
